// File: rtl/digit_column_scanner.sv
// digit_column_scanner: walks page / digit / column indices in SSD1306
// horizontal-addressing order, presents them to the 7-segment column decoder
// and streams the returned 8-pixel columns as a valid/ready byte stream.
// Optional build macro: SCANNER_BLANK_LEADING_ZEROS_EN blanks leading '0'
// digits (all but the rightmost) in the frame snapshot.
module digit_column_scanner #(
    parameter int DIGITS = 6,
    parameter int CHAR_W = 21,
    parameter int PAGES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIGITS*7-1:0]   segments_in,
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            digit_segments,
    output logic [4:0]            index_x,
    output logic [1:0]            index_y,
    input  logic [7:0]            pixels_column,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q, state_d;
    logic [4:0]      x_q;
    logic [DW-1:0]   d_q;
    logic [1:0]      y_q;
    logic            last_q;        // final column has been fetched
    logic [6:0]      snap_q [DIGITS];
    logic [7:0]      data_q;
    logic            valid_q;

    logic accept, slot_free, fetch, finish;
    logic x_end, d_end, y_end;

    assign accept    = (state_q == IDLE) && start;
    assign slot_free = !valid_q || out_ready;
    assign fetch     = (state_q == STREAM) && slot_free && !last_q;
    assign finish    = (state_q == STREAM) && last_q && valid_q && out_ready;
    assign x_end     = (x_q == 5'(CHAR_W - 1));
    assign d_end     = (d_q == DW'(DIGITS - 1));
    assign y_end     = (y_q == 2'(PAGES - 1));

`ifdef SCANNER_BLANK_LEADING_ZEROS_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              blank_run;

    // Leading-zero chain: a digit blanks only if it and everything left of it is '0'
    always_comb begin
        blank_d   = '0;
        blank_run = 1'b1;
        for (int i = 0; i < DIGITS - 1; i++) begin
            blank_run  = blank_run && (segments_in[7*i +: 7] == 7'h3F);
            blank_d[i] = blank_run;
        end
    end

    // Blank flags are captured together with the snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blank_q <= '0;
        else if (accept)
            blank_q <= blank_d;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: start only seen in IDLE, frame ends on final handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = STREAM;
            STREAM:  if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot, scan counters and the output byte register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) snap_q[i] <= '0;
            x_q     <= '0;
            d_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < DIGITS; i++) snap_q[i] <= segments_in[7*i +: 7];
            x_q    <= '0;
            d_q    <= '0;
            y_q    <= '0;
            last_q <= 1'b0;
        end else if (fetch) begin
            data_q  <= pixels_column;
            valid_q <= 1'b1;
            // Counters park on their terminal values after the final fetch
            if (x_end && d_end && y_end) begin
                last_q <= 1'b1;
            end else if (!x_end) begin
                x_q <= x_q + 5'd1;
            end else begin
                x_q <= '0;
                if (!d_end) begin
                    d_q <= d_q + DW'(1);
                end else begin
                    d_q <= '0;
                    y_q <= y_q + 2'd1;
                end
            end
        end else if (finish) begin
            valid_q <= 1'b0;
        end
    end

    // Output decode
    always_comb begin
        busy      = (state_q == STREAM);
        done      = finish;
        index_x   = x_q;
        index_y   = y_q;
        out_data  = data_q;
        out_valid = valid_q;
`ifdef SCANNER_BLANK_LEADING_ZEROS_EN
        digit_segments = blank_q[d_q] ? 7'h00 : snap_q[d_q];
`else
        digit_segments = snap_q[d_q];
`endif
    end

endmodule

// File: tb/tb_digit_column_scanner.sv
// Directed bench for digit_column_scanner: a DIGITS=2 instance for the
// streaming / handshake / reset corner cases and a DIGITS=4 instance driven
// from a vector table for the leading-zero blanking behaviour.
module tb_digit_column_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- DIGITS=2 instance ----------------
    logic        rst_n2, start2, busy2, done2, ov2, rdy2;
    logic [13:0] seg2;
    logic [6:0]  dseg2;
    logic [4:0]  ix2;
    logic [1:0]  iy2;
    logic [7:0]  pix2, od2;

    // Decoder model: {y, d[0], x}; d[0] recovered from segment bit a of the
    // chosen patterns (digit with bit a set reads as 1)
    assign pix2 = {iy2, dseg2[0], ix2};

    digit_column_scanner #(.DIGITS(2), .CHAR_W(21), .PAGES(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n2), .start(start2), .segments_in(seg2),
        .busy(busy2), .done(done2), .digit_segments(dseg2),
        .index_x(ix2), .index_y(iy2), .pixels_column(pix2),
        .out_data(od2), .out_valid(ov2), .out_ready(rdy2)
    );

    // ---------------- DIGITS=4 instance ----------------
    logic        rst_n4, start4, busy4, done4, ov4, rdy4;
    logic [27:0] seg4;
    logic [6:0]  dseg4;
    logic [4:0]  ix4;
    logic [1:0]  iy4;
    logic [7:0]  pix4, od4;

    // Decoder model echoes the presented segment pattern
    assign pix4 = {1'b0, dseg4};

    digit_column_scanner #(.DIGITS(4), .CHAR_W(21), .PAGES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n4), .start(start4), .segments_in(seg4),
        .busy(busy4), .done(done4), .digit_segments(dseg4),
        .index_x(ix4), .index_y(iy4), .pixels_column(pix4),
        .out_data(od4), .out_valid(ov4), .out_ready(rdy4)
    );

    // digit1 / digit0 patterns; bit a: 0x06 -> 0, 0x5B -> 1
    localparam logic [13:0] PAT_A = {7'h5B, 7'h06};
    localparam logic [13:0] PAT_B = {7'h06, 7'h5B};

    typedef struct {
        logic [27:0] segs;   // {d3,d2,d1,d0}
        logic [27:0] exp;    // expected digit_segments per digit, same packing
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] exp2(input int k, input bit flip);
        int x, d, y;
        x = k % 21;
        d = (k / 21) % 2;
        y = k / 42;
        return {2'(y), 1'(d) ^ flip, 5'(x)};
    endfunction

    // One frame on the DIGITS=2 instance, started at the current time
    task automatic frame2(input logic [13:0] pat, input bit flip, input bit rnd,
                          input bit disturb, input bit abort);
        int k, cyc, dones, first;
        bit stalled, fin, aborted;
        logic [7:0] held;
        k = 0; cyc = 0; dones = 0; first = -1;
        stalled = 0; fin = 0; aborted = 0; held = '0;
        seg2   = pat;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("busy_after_start", busy2, 1);
        chk("valid_after_start", ov2, 0);
        while (cyc < 3000 && !fin) begin
            rdy2   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start2 = 1'b0;
            if (disturb && k == 50) begin
                seg2   = ~pat;
                start2 = 1'b1;
            end
            #1;
            if (abort && k == 50) begin
                rst_n2 = 1'b0;
                #1;
                chk("abort_valid", ov2, 0);
                chk("abort_busy", busy2, 0);
                chk("abort_done", done2, 0);
                aborted = 1;
                break;
            end
            if (stalled) begin
                chk("stall_valid", ov2, 1);
                chk("stall_data", od2, held);
            end
            if (ov2 && first < 0) first = cyc;
            if (done2) begin
                dones++;
                chk("done_position", k, 167);
            end
            if (ov2 && rdy2) begin
                chk($sformatf("byte%0d", k), od2, exp2(k, flip));
                k++;
                fin = done2;
            end
            stalled = ov2 && !rdy2;
            held    = od2;
            @(posedge clk); #1;
            cyc++;
        end
        start2 = 1'b0;
        if (aborted) begin
            @(posedge clk); @(posedge clk); #2;
            rst_n2 = 1'b1;
            #1;
            chk("post_abort_busy", busy2, 0);
            chk("post_abort_done", done2, 0);
        end else begin
            chk("frame_timeout", fin, 1);
            chk("byte_count", k, 168);
            chk("done_count", dones, 1);
            chk("first_valid_latency", first, 1);
            chk("busy_after_done", busy2, 0);
            chk("valid_after_done", ov2, 0);
            chk("done_is_pulse", done2, 0);
            if (!rnd) chk("frame_cycles", cyc, 169);
        end
    endtask

    initial begin
        int k, cyc;
        bit fin;

        tbl[0].segs = {7'h3F, 7'h4F, 7'h3F, 7'h3F};
        tbl[1].segs = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
        tbl[2].segs = {7'h3F, 7'h3F, 7'h3F, 7'h06};
        tbl[3].segs = {7'h3F, 7'h3F, 7'h06, 7'h3F};
`ifdef SCANNER_BLANK_LEADING_ZEROS_EN
        tbl[0].exp  = {7'h3F, 7'h4F, 7'h00, 7'h00};
        tbl[1].exp  = {7'h3F, 7'h00, 7'h00, 7'h00};
        tbl[2].exp  = {7'h3F, 7'h3F, 7'h3F, 7'h06};
        tbl[3].exp  = {7'h3F, 7'h3F, 7'h06, 7'h00};
`else
        for (int i = 0; i < 4; i++) tbl[i].exp = tbl[i].segs;
`endif

        rst_n2 = 1'b0; start2 = 1'b0; seg2 = PAT_A; rdy2 = 1'b1;
        rst_n4 = 1'b0; start4 = 1'b0; seg4 = '0;   rdy4 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_valid", ov2, 0);
        chk("rst_data", od2, 8'h00);
        chk("rst_index_x", ix2, 0);
        chk("rst_index_y", iy2, 0);
        chk("rst_segments", dseg2, 0);
        rst_n2 = 1'b1;
        rst_n4 = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy2, 0);

        // Full frame, then a back-to-back frame with new patterns
        frame2(PAT_A, 1'b0, 1'b0, 1'b0, 1'b0);
        frame2(PAT_B, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        // Random backpressure
        frame2(PAT_A, 1'b0, 1'b1, 1'b0, 1'b0);
        // Mid-frame pattern change and start pulse are ignored
        frame2(PAT_A, 1'b0, 1'b0, 1'b1, 1'b0);
        // Reset at byte 50, then a clean frame
        frame2(PAT_A, 1'b0, 1'b0, 1'b0, 1'b1);
        frame2(PAT_B, 1'b1, 1'b1, 1'b0, 1'b0);

        // Blanking table on the DIGITS=4 instance
        for (int v = 0; v < 4; v++) begin
            seg4   = tbl[v].segs;
            start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
            k = 0; cyc = 0; fin = 0;
            while (cyc < 1000 && !fin) begin
                #1;
                if (ov4) begin
                    if (k % 21 == 0 && k < 84)
                        chk($sformatf("vec%0d_digit%0d", v, k / 21), od4,
                            {1'b0, tbl[v].exp[7*(k/21) +: 7]});
                    k++;
                    fin = done4;
                end
                @(posedge clk); #1;
                cyc++;
            end
            chk($sformatf("vec%0d_bytes", v), k, 336);
            chk($sformatf("vec%0d_busy", v), busy4, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
